// File: rtl/caravan_signal_gen.sv
// Wishbone-programmable pattern generator driving five user pads.
// Prescaled up/down/walking-one sequencer with a saturating wrap counter.
module caravan_signal_gen #(
  parameter logic [15:0] DIV_DEFAULT  = 16'd3,
  parameter logic [2:0]  CTRL_DEFAULT = 3'b001
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        i_test,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [4:0]  o_result,
  output logic [4:0]  io_oeb
);

  localparam int unsigned RES_W  = 5;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned WRAP_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] ID_VALUE = 32'h5347_0001;

  typedef enum logic [1:0] {
    ADR_CTRL   = 2'd0,
    ADR_DIV    = 2'd1,
    ADR_STATUS = 2'd2,
    ADR_ID     = 2'd3
  } adr_e;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_WALK   = 2'b10,
    MODE_UP_ALT = 2'b11
  } mode_e;

  logic [1:0]        sync_q;
  logic [2:0]        ctrl_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  presc_q;
  logic [WRAP_W-1:0] wrap_q;

  logic              req_c, wr_c, wr_ctrl_c, wr_div_c, wr_blk_c, mode_chg_c;
  logic              run_c, tick_c, wrap_inc_c;
  logic [RES_W-1:0]  res_nxt_c;
  logic [DIV_W-1:0]  div_nxt_c;
  logic [DATA_W-1:0] rd_mux_c;
  adr_e              adr_c;
  mode_e             mode_c;
  logic              unused_c;

  assign io_oeb   = '0;
  assign unused_c = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  // Bus decode: a request is accepted only when no ack is outstanding
  assign adr_c      = adr_e'(wbs_adr_i[3:2]);
  assign req_c      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_c       = req_c & wbs_we_i;
  assign wr_ctrl_c  = wr_c & (adr_c == ADR_CTRL) & wbs_sel_i[0];
  assign wr_div_c   = wr_c & (adr_c == ADR_DIV);
  assign wr_blk_c   = wr_ctrl_c | wr_div_c;
  assign mode_chg_c = wr_ctrl_c & (wbs_dat_i[2:1] != ctrl_q[2:1]);
  assign div_nxt_c  = {wbs_sel_i[1] ? wbs_dat_i[15:8] : div_q[15:8],
                       wbs_sel_i[0] ? wbs_dat_i[7:0]  : div_q[7:0]};

  assign mode_c = mode_e'(ctrl_q[2:1]);
  assign run_c  = sync_q[1] & ctrl_q[0];
  assign tick_c = run_c & (presc_q == div_q);

  // Next pattern value and wrap detection for the current mode
  always_comb begin
    res_nxt_c  = o_result;
    wrap_inc_c = 1'b0;
    case (mode_c)
      MODE_DOWN: begin
        res_nxt_c  = o_result - RES_W'(1);
        wrap_inc_c = (o_result == '0);
      end
      MODE_WALK: begin
        if ((o_result != '0) && ((o_result & (o_result - RES_W'(1))) == '0)) begin
          res_nxt_c  = {o_result[RES_W-2:0], o_result[RES_W-1]};
          wrap_inc_c = o_result[RES_W-1];
        end else begin
          res_nxt_c = RES_W'(1);
        end
      end
      default: begin
        res_nxt_c  = o_result + RES_W'(1);
        wrap_inc_c = &o_result;
      end
    endcase
  end

  always_comb begin
    rd_mux_c = '0;
    case (adr_c)
      ADR_CTRL:   rd_mux_c = DATA_W'(ctrl_q);
      ADR_DIV:    rd_mux_c = DATA_W'(div_q);
      ADR_STATUS: rd_mux_c = DATA_W'({wrap_q, 2'b00, run_c, o_result});
      default:    rd_mux_c = ID_VALUE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_q    <= '0;
      ctrl_q    <= CTRL_DEFAULT;
      div_q     <= DIV_DEFAULT;
      presc_q   <= '0;
      wrap_q    <= '0;
      o_result  <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      sync_q    <= {sync_q[0], i_test};
      wbs_ack_o <= req_c;
      wbs_dat_o <= req_c ? rd_mux_c : '0;

      if (wr_ctrl_c) ctrl_q <= wbs_dat_i[2:0];
      if (wr_div_c)  div_q  <= div_nxt_c;

      if (mode_chg_c || wr_div_c) presc_q <= '0;
      else if (run_c)             presc_q <= tick_c ? '0 : presc_q + DIV_W'(1);

      // A committed register write takes priority over a coincident tick
      if (mode_chg_c)
        o_result <= (wbs_dat_i[2:1] == MODE_WALK) ? RES_W'(1) : '0;
      else if (tick_c && !wr_blk_c)
        o_result <= res_nxt_c;

      if (wr_ctrl_c && wbs_dat_i[3])
        wrap_q <= '0;
      else if (tick_c && !wr_blk_c && wrap_inc_c && (wrap_q != '1))
        wrap_q <= wrap_q + WRAP_W'(1);
    end
  end

endmodule

// File: tb/tb_caravan_signal_gen.sv
// Self-checking bench for caravan_signal_gen: register table, pattern
// sequences, pause/resume, wrap saturation and asynchronous reset abort.
module tb_caravan_signal_gen;

  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_DIV  = 32'h4;
  localparam logic [31:0] A_STAT = 32'h8;
  localparam logic [31:0] A_ID   = 32'hC;
  localparam logic [31:0] ALL    = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        resetb = 1'b1;
  logic        i_test = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic [4:0]  o_result;
  logic [4:0]  io_oeb;

  caravan_signal_gen dut (
    .clock(clock), .resetb(resetb), .i_test(i_test),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .o_result(o_result), .io_oeb(io_oeb)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] expv;
    logic [31:0] mask;
  } sb_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] expv;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[20];
  int   checks = 0;
  int   failures = 0;
  logic ack_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_res(input string name, input int expv);
    chk(name, 32'(o_result), 32'(expv % 32));
  endtask

  // Drives one classic cycle from a negedge; read data is popped on ack
  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d);
    int  n;
    sb_t e;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
    wbs_adr_i = a; wbs_sel_i = s; wbs_dat_i = d;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!wbs_ack_o && n < 8);
    if (!wbs_ack_o) begin
      checks++; failures++;
      $display("FAIL bus_timeout adr=%h actual=no_ack required=ack", a);
      if (!w && sb_q.size() > 0) e = sb_q.pop_front();
    end else if (!w) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL read_unexpected adr=%h actual=%h required=none", a, wbs_dat_o);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("read_%h", e.adr), wbs_dat_o & e.mask, e.expv);
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] expv, input logic [31:0] mask);
    sb_t e;
    e.adr = a; e.expv = expv; e.mask = mask;
    sb_q.push_back(e);
    bus(1'b0, a, 4'hF, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bus(1'b1, a, s, d);
  endtask

  // Acknowledge must never last longer than one cycle
  always @(negedge clock) begin
    if (wbs_ack_o) begin
      checks++;
      if (ack_prev) begin
        failures++;
        $display("FAIL ack_width actual=multi_cycle required=single_cycle t=%0t", $time);
      end
    end
    ack_prev = wbs_ack_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, A_CTRL, 4'hF, 32'h0,         32'h0000_0001};
    vecs[1]  = '{1'b0, A_DIV,  4'hF, 32'h0,         32'h0000_0003};
    vecs[2]  = '{1'b0, A_ID,   4'hF, 32'h0,         32'h5347_0001};
    vecs[3]  = '{1'b0, A_STAT, 4'hF, 32'h0,         32'h0000_0000};
    vecs[4]  = '{1'b1, A_DIV,  4'h1, 32'hFFFF_FF07, 32'h0};
    vecs[5]  = '{1'b0, A_DIV,  4'hF, 32'h0,         32'h0000_0007};
    vecs[6]  = '{1'b1, A_DIV,  4'h2, 32'h0000_1200, 32'h0};
    vecs[7]  = '{1'b0, A_DIV,  4'hF, 32'h0,         32'h0000_1207};
    vecs[8]  = '{1'b1, A_DIV,  4'hF, 32'hABCD_0003, 32'h0};
    vecs[9]  = '{1'b0, A_DIV,  4'hF, 32'h0,         32'h0000_0003};
    vecs[10] = '{1'b1, A_CTRL, 4'hF, 32'hFFFF_FFF7, 32'h0};
    vecs[11] = '{1'b0, A_CTRL, 4'hF, 32'h0,         32'h0000_0007};
    vecs[12] = '{1'b1, A_ID,   4'hF, 32'h0000_0000, 32'h0};
    vecs[13] = '{1'b0, A_ID,   4'hF, 32'h0,         32'h5347_0001};
    vecs[14] = '{1'b1, A_STAT, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[15] = '{1'b0, A_STAT, 4'hF, 32'h0,         32'h0000_0000};
    vecs[16] = '{1'b1, A_CTRL, 4'h1, 32'h0000_0001, 32'h0};
    vecs[17] = '{1'b0, A_CTRL, 4'hF, 32'h0,         32'h0000_0001};
    vecs[18] = '{1'b1, A_CTRL, 4'h0, 32'h0000_0006, 32'h0};
    vecs[19] = '{1'b0, A_CTRL, 4'hF, 32'h0,         32'h0000_0001};

    // Reset state
    #3 resetb = 1'b0;
    #1;
    chk("rst_result", 32'(o_result), 32'h0);
    chk("rst_ack", 32'(wbs_ack_o), 32'h0);
    chk("rst_oeb", 32'(io_oeb), 32'h0);
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    @(negedge clock);

    // Register map table, run held off
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].we) wr(vecs[i].adr, vecs[i].sel, vecs[i].dat);
      else            rd(vecs[i].adr, vecs[i].expv, ALL);
    end

    // Default up-count, DIV=3: value steps every 4 cycles after 2-cycle sync
    i_test = 1'b1;
    for (int p = 1; p <= 130; p++) begin
      @(posedge clock); @(negedge clock);
      chk_res($sformatf("up_p%0d", p), (p < 2) ? 0 : (p - 2) / 4);
    end
    chk("oeb_run", 32'(io_oeb), 32'h0);
    rd(A_STAT, 32'h0000_0120, 32'h0000_FF20);

    // DIV=0: one step per cycle, then a 10-cycle pause
    begin
      int v0;
      wr(A_DIV, 4'hF, 32'h0);
      v0 = int'(o_result);
      for (int k = 1; k <= 8; k++) begin
        @(posedge clock); @(negedge clock);
        chk_res($sformatf("div0_k%0d", k), v0 + k);
      end
      v0 = int'(o_result);
      i_test = 1'b0;
      for (int p = 1; p <= 14; p++) begin
        @(posedge clock); @(negedge clock);
        chk_res($sformatf("pause_p%0d", p), v0 + ((p <= 2) ? p : (p <= 12) ? 2 : p - 10));
        if (p == 10) i_test = 1'b1;
      end
    end

    // Down-count: 0, 31, 30
    wr(A_CTRL, 4'hF, 32'h0000_0003);
    chk_res("down_0", 0);
    @(posedge clock); @(negedge clock);
    chk_res("down_31", 31);
    @(posedge clock); @(negedge clock);
    chk_res("down_30", 30);

    // Walking one with wrap counter cleared by CTRL bit3
    begin
      int walk[5] = '{1, 2, 4, 8, 16};
      wr(A_CTRL, 4'hF, 32'h0000_000D);
      chk_res("walk_load", 1);
      for (int k = 1; k <= 14; k++) begin
        @(posedge clock); @(negedge clock);
        chk_res($sformatf("walk_k%0d", k), (k <= 12) ? walk[k % 5] : 4);
        if (k == 10) i_test = 1'b0;
      end
      rd(A_STAT, 32'h0000_0204, ALL);
      rd(A_CTRL, 32'h0000_0005, ALL);
    end

    // Wrap counter saturates at 255
    i_test = 1'b1;
    repeat (1300) @(negedge clock);
    i_test = 1'b0;
    repeat (4) @(negedge clock);
    rd(A_STAT, 32'h0000_FF00, 32'h0000_FF20);

    // Reset pulse in the middle of counting and of an acked bus cycle
    wr(A_DIV, 4'hF, 32'h0000_0005);
    wr(A_CTRL, 4'hF, 32'h0000_0003);
    i_test = 1'b1;
    repeat (20) @(negedge clock);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = A_ID; wbs_sel_i = 4'hF;
    #6;
    resetb = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    #1;
    chk("arst_result", 32'(o_result), 32'h0);
    chk("arst_ack", 32'(wbs_ack_o), 32'h0);
    chk("arst_dat", wbs_dat_o, 32'h0);
    #2 resetb = 1'b1;
    @(negedge clock);
    for (int p = 1; p <= 6; p++) begin
      @(posedge clock); @(negedge clock);
      chk_res($sformatf("post_rst_p%0d", p), (p >= 6) ? 1 : 0);
      chk($sformatf("post_rst_ack_p%0d", p), 32'(wbs_ack_o), 32'h0);
    end
    rd(A_CTRL, 32'h0000_0001, ALL);
    rd(A_DIV, 32'h0000_0003, ALL);

    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
